// File: rtl/acc_group.sv
// acc_group: per-lane sum of num_reads_per_iter product groups, num_iters results, via a 2-slot input buffer and valid/avail handshakes
module acc_group #(
  parameter int GROUP_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int LOG_MAX_ITERS = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]  data_in,
  input  logic                              valid_in,
  output logic                              avail_out,
  output logic [GROUP_SIZE*ACC_WIDTH-1:0]   data_out,
  output logic                              valid_out,
  input  logic                              avail_in,
  output logic                              busy,
  output logic                              overflow_err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [GROUP_SIZE*DATA_WIDTH-1:0] mem [2];
  logic [1:0] occ;
  logic wr_ptr, rd_ptr;
  logic [LOG_MAX_ITERS-1:0] iter_cnt;
  logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt, reads_cfg;
  logic [GROUP_SIZE*ACC_WIDTH-1:0] acc, sum;
  logic pending, start, last, consume, wr;
  assign start = configure && num_iters != '0 && num_reads_per_iter != '0;
  assign last = read_cnt == LOG_MAX_READS_PER_ITER'(1);
  assign consume = state == RUN && !configure && occ != 2'd0 && !(last && pending && !avail_in);
  assign wr = valid_in && occ != 2'd2;
  assign valid_out = pending && avail_in;
  assign busy = state != IDLE;
  assign avail_out = rst && occ == 2'd0;
  for (genvar i = 0; i < GROUP_SIZE; i++) begin : g_lane
    assign sum[i*ACC_WIDTH +: ACC_WIDTH] = acc[i*ACC_WIDTH +: ACC_WIDTH] + ACC_WIDTH'(mem[rd_ptr][i*DATA_WIDTH +: DATA_WIDTH]);
  end
  always_comb begin
    state_nx = state;
    if (configure) state_nx = start ? RUN : IDLE;
    else if (state == RUN && consume && last && iter_cnt == LOG_MAX_ITERS'(1)) state_nx = DRAIN;
    else if (state == DRAIN && (!pending || avail_in)) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      overflow_err <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= data_in;
        wr_ptr <= !wr_ptr;
      end
      if (consume) rd_ptr <= !rd_ptr;
      occ <= occ + 2'(wr) - 2'(consume);
      if (valid_in && occ == 2'd2) overflow_err <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pending <= 1'b0;
      iter_cnt <= '0;
      read_cnt <= '0;
      reads_cfg <= '0;
      acc <= '0;
      data_out <= '0;
    end else begin
      state <= state_nx;
      if (configure) begin
        if (start) begin
          iter_cnt <= num_iters;
          read_cnt <= num_reads_per_iter;
          reads_cfg <= num_reads_per_iter;
        end
        acc <= '0;
        pending <= 1'b0;
      end else if (consume && last) begin
        data_out <= sum;
        acc <= '0;
        pending <= 1'b1;
        read_cnt <= reads_cfg;
        iter_cnt <= iter_cnt - LOG_MAX_ITERS'(1);
      end else begin
        if (consume) begin
          acc <= sum;
          read_cnt <= read_cnt - LOG_MAX_READS_PER_ITER'(1);
        end
        if (valid_out) pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_acc_group.sv
// tb_acc_group: table, hand-written and randomized checks of acc_group against a lane-sum model
module tb_acc_group;
  logic clk = 0, rst = 0, configure = 0, valid_in = 0, avail_in = 0;
  logic [15:0] num_iters = 0, num_reads_per_iter = 0;
  logic [63:0] data_in = 0;
  logic avail_out, valid_out, busy, overflow_err;
  logic [127:0] data_out;
  logic avail_out17, valid_out17, busy17, overflow_err17;
  logic [67:0] data_out17;
  int total = 0, bad = 0;
  logic [63:0] inq[$];
  logic [127:0] got[$];
  logic [67:0] got17[$];
  typedef struct { int it; int rd; logic [63:0] d; logic [127:0] e; } vec_t;
  vec_t tbl[4];
  always #5 clk = ~clk;
  acc_group dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads_per_iter), .data_in(data_in), .valid_in(valid_in),
    .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out), .avail_in(avail_in),
    .busy(busy), .overflow_err(overflow_err)
  );
  acc_group #(.ACC_WIDTH(17)) dut17 (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads_per_iter), .data_in(data_in), .valid_in(valid_in),
    .avail_out(avail_out17), .data_out(data_out17), .valid_out(valid_out17), .avail_in(avail_in),
    .busy(busy17), .overflow_err(overflow_err17)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] grp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction
  function automatic logic [127:0] res(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction
  function automatic logic [127:0] model(input int it, input int rd);
    logic [127:0] r;
    logic [31:0] s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int j = 0; j < rd; j++) s += 32'(inq[it*rd+j][k*16 +: 16]);
      r[k*32 +: 32] = s;
    end
    return r;
  endfunction
  task automatic cfg(input int it, input int rd);
    @(negedge clk);
    configure = 1;
    num_iters = 16'(it);
    num_reads_per_iter = 16'(rd);
    @(negedge clk);
    configure = 0;
  endtask
  task automatic put(input logic [63:0] d);
    int c = 0;
    while (!avail_out && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c == 100) begin
      total++;
      bad++;
      $display("FAIL put_timeout: avail_out stuck at %b, required 1", avail_out);
    end
    valid_in = 1;
    data_in = d;
    @(negedge clk);
    valid_in = 0;
  endtask
  task automatic run_job(input int it, input int rd, input bit rnd);
    int extra = 0;
    got.delete();
    got17.delete();
    cfg(it, rd);
    fork
      begin
        int idx = 0;
        for (int c = 0; c < 3000 && idx < inq.size(); c++) begin
          if (avail_out) begin
            valid_in = 1;
            data_in = inq[idx];
            idx++;
          end else valid_in = 0;
          @(negedge clk);
        end
        valid_in = 0;
      end
      begin
        int c = 0;
        while (got.size() < it && c < 3000) begin
          avail_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          #1;
          if (valid_out) begin
            got.push_back(data_out);
            got17.push_back(data_out17);
          end
          @(negedge clk);
          c++;
        end
      end
    join
    chk("job_count", 128'(got.size()), 128'(it));
    chk("busy_after_last", busy, 1'b0);
    avail_in = 1;
    repeat (4) begin
      #1;
      if (valid_out) extra++;
      @(negedge clk);
    end
    chk("no_extra_out", 128'(extra), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  initial begin
    int it, rd;
    tbl[0] = '{1, 1, grp(7, 0, 1, 65535), res(7, 0, 1, 65535)};
    tbl[1] = '{2, 4, grp(1, 2, 3, 4), res(4, 8, 12, 16)};
    tbl[2] = '{1, 2, grp(65535, 65535, 1, 0), res(131070, 131070, 2, 0)};
    tbl[3] = '{3, 5, grp(100, 200, 300, 400), res(500, 1000, 1500, 2000)};
    repeat (2) @(negedge clk);
    chk("rst_outputs", {busy, valid_out, overflow_err, avail_out}, 0);
    chk("rst_data", data_out, 0);
    chk("rst_outputs17", {busy17, valid_out17, overflow_err17, avail_out17}, 0);
    rst = 1;
    @(negedge clk);
    chk("idle_avail", avail_out, 1'b1);
    chk("idle_busy", busy, 1'b0);
    valid_in = 1;
    data_in = grp(1, 1, 1, 1);
    repeat (2) @(negedge clk);
    chk("two_writes_no_ovf", overflow_err, 1'b0);
    chk("two_writes_full", avail_out, 1'b0);
    @(negedge clk);
    valid_in = 0;
    chk("third_write_ovf", overflow_err, 1'b1);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", overflow_err, 1'b1);
    chk("ovf_full", avail_out, 1'b0);
    #2 rst = 0;
    #1 chk("ovf_cleared", {overflow_err, avail_out}, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("buf_cleared", avail_out, 1'b1);
    inq = {grp(1, 2, 3, 4), grp(1, 2, 3, 4), grp(1, 2, 3, 4), grp(10, 20, 30, 40), grp(10, 20, 30, 40), grp(10, 20, 30, 40)};
    run_job(2, 3, 0);
    chk("basic0", got[0], res(3, 6, 9, 12));
    chk("basic1", got[1], res(30, 60, 90, 120));
    for (int i = 0; i < 4; i++) begin
      inq.delete();
      repeat (tbl[i].it * tbl[i].rd) inq.push_back(tbl[i].d);
      run_job(tbl[i].it, tbl[i].rd, i[0]);
      for (int r = 0; r < tbl[i].it; r++) chk($sformatf("tbl%0d_%0d", i, r), got[r], tbl[i].e);
    end
    avail_in = 0;
    cfg(2, 1);
    put(grp(5, 5, 5, 5));
    put(grp(7, 7, 7, 7));
    repeat (4) @(negedge clk);
    chk("bp_held", {valid_out, avail_out, busy}, 3'b001);
    chk("bp_data", data_out, res(5, 5, 5, 5));
    avail_in = 1;
    #1 chk("bp_out0", {valid_out, data_out}, {1'b1, res(5, 5, 5, 5)});
    @(negedge clk);
    #1 chk("bp_out1", {valid_out, data_out}, {1'b1, res(7, 7, 7, 7)});
    @(negedge clk);
    chk("bp_done", {busy, valid_out}, 0);
    inq = {grp(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), grp(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), grp(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF)};
    run_job(1, 3, 0);
    chk("wrap17", 128'(got17[0]), 128'({4{17'h0FFFD}}));
    chk("wrap32", got[0], res(32'h2FFFD, 32'h2FFFD, 32'h2FFFD, 32'h2FFFD));
    cfg(1, 4);
    put(grp(1, 1, 1, 1));
    put(grp(2, 2, 2, 2));
    repeat (3) @(negedge clk);
    inq = {grp(9, 9, 9, 9)};
    run_job(1, 1, 0);
    chk("restart", got[0], res(9, 9, 9, 9));
    cfg(0, 3);
    chk("zero_iters", busy, 1'b0);
    cfg(2, 0);
    chk("zero_reads", busy, 1'b0);
    begin
      int seen = 0;
      repeat (10) begin
        #1;
        if (valid_out || busy) seen++;
        @(negedge clk);
      end
      chk("zero_quiet", 128'(seen), 0);
    end
    repeat (6) begin
      it = $urandom_range(1, 3);
      rd = $urandom_range(1, 4);
      inq.delete();
      repeat (it * rd) inq.push_back({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
      run_job(it, rd, 1);
      for (int r = 0; r < it; r++) chk($sformatf("rand_%0d_%0d", rd, r), got[r], model(r, rd));
    end
    avail_in = 0;
    cfg(2, 2);
    put(grp(3, 3, 3, 3));
    put(grp(3, 3, 3, 3));
    repeat (3) @(negedge clk);
    put(grp(4, 4, 4, 4));
    repeat (2) @(negedge clk);
    avail_in = 1;
    #1 chk("pre_rst_pending", {valid_out, busy, data_out}, {2'b11, res(6, 6, 6, 6)});
    #1 rst = 0;
    #1 chk("async_rst_ctl", {busy, valid_out, overflow_err, avail_out}, 0);
    chk("async_rst_data", data_out, 0);
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {busy, valid_out, avail_out}, 3'b001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
